// File: rtl/decim_pkg.sv
// Shared types and helper functions for the streaming frame decimator.
package decim_pkg;

    typedef enum logic {
        DECIM_DROP = 1'b0,
        DECIM_AVG  = 1'b1
    } decim_mode_t;

    function automatic int acc_width(input int pixel_w, input int max_log2);
        return pixel_w + 32'sd2 * max_log2;
    endfunction

    function automatic logic [1:0] clamp_log2(input logic [1:0] cfg, input logic [1:0] max_log2);
        logic [1:0] res;
        if (cfg > max_log2) begin
            res = max_log2;
        end else begin
            res = cfg;
        end
        return res;
    endfunction

endpackage

// File: rtl/decim_linha_acc.sv
// Row accumulator: one partial block sum per output column, combinational read,
// synchronous write-or-accumulate.
module decim_linha_acc
    import decim_pkg::*;
#(
    parameter int DEPTH   = 160,
    parameter int PIXEL_W = 8,
    parameter int ACC_W   = acc_width(PIXEL_W, 32'sd2),
    parameter int IDX_W   = 8
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic               wr_first,
    input  logic [IDX_W-1:0]   idx,
    input  logic [PIXEL_W-1:0] din,
    output logic [ACC_W-1:0]   rd_data
);

    logic [ACC_W-1:0] mem_r [DEPTH];
    logic [ACC_W-1:0] wr_data_s;

    assign rd_data = mem_r[idx];

    // Select between starting a fresh block sum and adding to the stored one.
    always_comb begin
        wr_data_s = '0;
        if (wr_first) begin
            wr_data_s = ACC_W'(din);
        end else begin
            wr_data_s = rd_data + ACC_W'(din);
        end
    end

    // Storage update; no reset because a block's first pixel always overwrites.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[idx] <= wr_data_s;
        end
    end

endmodule

// File: rtl/decimacao_stream.sv
// Streaming power-of-two frame decimator (drop or rounded block mean) with
// valid/ready handshake on both sides and a single-entry output register.
module decimacao_stream
    import decim_pkg::*;
#(
    parameter int IMG_W    = 160,
    parameter int IMG_H    = 120,
    parameter int PIXEL_W  = 8,
    parameter int MAX_LOG2 = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         cfg_log2,
    input  logic               cfg_mode,
    input  logic [PIXEL_W-1:0] in_pixel,
    input  logic               in_valid,
    input  logic               in_sof,
    output logic               in_ready,
    output logic [PIXEL_W-1:0] out_pixel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sof,
    output logic               out_eol,
    output logic               frame_done
);

    localparam int XW = $clog2(IMG_W + 32'sd1);
    localparam int YW = $clog2(IMG_H + 32'sd1);
    localparam int AW = acc_width(PIXEL_W, MAX_LOG2);
    localparam int SW = AW + 32'sd1;
    localparam logic [1:0]    K_MAX  = 2'(MAX_LOG2);
    localparam logic [XW-1:0] X_ONE  = XW'(1'b1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1'b1);
    localparam logic [SW-1:0] S_ONE  = SW'(1'b1);
    localparam logic [XW-1:0] X_FULL = XW'(IMG_W);
    localparam logic [YW-1:0] Y_FULL = YW'(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 32'sd1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 32'sd1);

    logic [XW-1:0]      x_r, cur_x_s, x_next_s, x_mask_s, ox_s, ox_last_s;
    logic [YW-1:0]      y_r, cur_y_s, y_next_s, y_mask_s, oy_s, oy_last_s;
    logic [1:0]         k_r, eff_k_s;
    decim_mode_t        mode_r, eff_mode_s;
    logic               xfer_s, frame_start_s, blk_first_s, blk_last_s, gen_s, acc_we_s, last_s;
    logic [2:0]         sh2k_s;
    logic [AW-1:0]      acc_rd_s, acc_term_s;
    logic [SW-1:0]      round_s, sum_s;
    logic [PIXEL_W-1:0] avg_s, res_pixel_s;
    logic [PIXEL_W-1:0] out_pixel_r;
    logic               out_valid_r, out_sof_r, out_eol_r, out_last_r, frame_done_r;

    assign in_ready   = !out_valid_r || out_ready;
    assign xfer_s     = in_valid && in_ready;
    assign out_pixel  = out_pixel_r;
    assign out_valid  = out_valid_r;
    assign out_sof    = out_sof_r;
    assign out_eol    = out_eol_r;
    assign frame_done = frame_done_r;

    // Decode position, effective configuration and output trigger for the pixel on the bus.
    always_comb begin
        cur_x_s = x_r;
        cur_y_s = y_r;
        eff_k_s = k_r;
        eff_mode_s = mode_r;
        x_next_s = '0;
        y_next_s = '0;
        round_s = '0;
        gen_s = 1'b0;
        res_pixel_s = '0;
        if (in_sof) begin
            cur_x_s = '0;
            cur_y_s = '0;
        end else begin
            cur_x_s = x_r;
            cur_y_s = y_r;
        end
        frame_start_s = (cur_x_s == '0) && (cur_y_s == '0);
        // Configuration only takes effect on the first pixel of a frame.
        if (frame_start_s) begin
            eff_k_s = clamp_log2(cfg_log2, K_MAX);
            eff_mode_s = decim_mode_t'(cfg_mode);
        end else begin
            eff_k_s = k_r;
            eff_mode_s = mode_r;
        end
        x_mask_s    = (X_ONE << eff_k_s) - X_ONE;
        y_mask_s    = (Y_ONE << eff_k_s) - Y_ONE;
        blk_first_s = ((cur_x_s & x_mask_s) == '0) && ((cur_y_s & y_mask_s) == '0);
        blk_last_s  = ((cur_x_s & x_mask_s) == x_mask_s) && ((cur_y_s & y_mask_s) == y_mask_s);
        ox_s        = cur_x_s >> eff_k_s;
        oy_s        = cur_y_s >> eff_k_s;
        ox_last_s   = (X_FULL >> eff_k_s) - X_ONE;
        oy_last_s   = (Y_FULL >> eff_k_s) - Y_ONE;
        last_s      = (ox_s == ox_last_s) && (oy_s == oy_last_s);
        sh2k_s      = {1'b0, eff_k_s} << 1'b1;
        if (eff_k_s == 2'd0) begin
            round_s = '0;
        end else begin
            round_s = S_ONE << (sh2k_s - 3'd1);
        end
        // A single-pixel block has no earlier partial sum to add.
        acc_term_s = blk_first_s ? '0 : acc_rd_s;
        sum_s      = SW'(acc_term_s) + SW'(in_pixel) + round_s;
        avg_s      = PIXEL_W'(sum_s >> sh2k_s);
        if (eff_mode_s == DECIM_AVG) begin
            gen_s = blk_last_s;
            res_pixel_s = avg_s;
        end else begin
            gen_s = blk_first_s;
            res_pixel_s = in_pixel;
        end
        acc_we_s = xfer_s && (eff_mode_s == DECIM_AVG);
        if (cur_x_s == X_LAST) begin
            x_next_s = '0;
            if (cur_y_s == Y_LAST) begin
                y_next_s = '0;
            end else begin
                y_next_s = cur_y_s + Y_ONE;
            end
        end else begin
            x_next_s = cur_x_s + X_ONE;
            y_next_s = cur_y_s;
        end
    end

    decim_linha_acc #(
        .DEPTH  (IMG_W),
        .PIXEL_W(PIXEL_W),
        .ACC_W  (AW),
        .IDX_W  (XW)
    ) u_acc (
        .clk     (clk),
        .wr_en   (acc_we_s),
        .wr_first(blk_first_s),
        .idx     (ox_s),
        .din     (in_pixel),
        .rd_data (acc_rd_s)
    );

    // Raster counters and per-frame configuration latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r    <= '0;
            y_r    <= '0;
            k_r    <= K_MAX;
            mode_r <= DECIM_DROP;
        end else if (xfer_s) begin
            x_r    <= x_next_s;
            y_r    <= y_next_s;
            k_r    <= eff_k_s;
            mode_r <= eff_mode_s;
        end
    end

    // Single-entry output register, held while downstream stalls, plus end-of-frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            out_pixel_r  <= '0;
            out_sof_r    <= 1'b0;
            out_eol_r    <= 1'b0;
            out_last_r   <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= out_valid_r && out_ready && out_last_r;
            if (xfer_s && gen_s) begin
                out_valid_r <= 1'b1;
                out_pixel_r <= res_pixel_s;
                out_sof_r   <= (ox_s == '0) && (oy_s == '0);
                out_eol_r   <= (ox_s == ox_last_s);
                out_last_r  <= last_s;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: doc/decimacao_stream.md
# decimacao_stream

Streaming, parametrised successor to the fixed 160×120→40×30 frame decimator. It accepts raster-order pixels over a valid/ready handshake and downscales each frame by a power-of-two factor chosen at run time. Two modes are supported: keeping the top-left pixel of each block (drop) or outputting the rounded mean of each block (average). It sits between the camera/frame-read path and the VGA/frame-write path of the scaling pipeline.

## Interface
- `IMG_W`, 160: input frame width in pixels; must be divisible by 2^MAX_LOG2.
- `IMG_H`, 120: input frame height in lines; must be divisible by 2^MAX_LOG2.
- `PIXEL_W`, 8: pixel width in bits (grayscale).
- `MAX_LOG2`, 2: largest supported log2 factor (2 → factor 4).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_log2`  in  2  log2 of the decimation factor; values > MAX_LOG2 clamp to MAX_LOG2.
- `cfg_mode`  in  1  0 = drop (top-left pixel), 1 = block average.
- `in_pixel`  in  PIXEL_W  input pixel.
- `in_valid`  in  1  input pixel valid.
- `in_sof`  in  1  marks the first pixel of a frame; sampled only with `in_valid`.
- `in_ready`  out  1  block can accept a pixel this cycle.
- `out_pixel`  out  PIXEL_W  decimated pixel.
- `out_valid`  out  1  output valid.
- `out_ready`  in  1  downstream accepts.
- `out_sof`  out  1  first output pixel of the frame.
- `out_eol`  out  1  last output pixel of an output line.
- `frame_done`  out  1  one-cycle pulse after the last output pixel of a frame is accepted.

## Operation
- An input transfer occurs when `in_valid && in_ready`. Counters `x` (0..IMG_W-1) and `y` (0..IMG_H-1) advance per transfer and wrap to (0,0) after (IMG_W-1, IMG_H-1).
- `in_sof` on a transfer forces that pixel to be treated as (0,0), resynchronising the frame. Any partial block sums are discarded.
- `cfg_log2` (k, after clamping) and `cfg_mode` are latched on the transfer at (0,0). Changes mid-frame are ignored until the next frame. Block size is F = 2^k and the mask is F-1.
- Drop mode: an output is produced on the transfer where `(x&mask)==0 && (y&mask)==0`, with `out_pixel = in_pixel`.
- Average mode:
  - A row accumulator `acc[x>>k]` is PIXEL_W+2·MAX_LOG2 bits wide and IMG_W/1 entries deep; only IMG_W>>k entries are used.
  - On the first pixel of a block (both coordinates masked to 0), the entry is written with `in_pixel`. On every other pixel of the block, `in_pixel` is added to the entry.
  - The output is produced on the transfer where `(x&mask)==mask && (y&mask)==mask`.
  - `out_pixel = (acc + in_pixel + (k>0 ? 1<<(2k-1) : 0)) >> 2k`, which is round-half-up. No saturation is needed because the mean is at most 2^PIXEL_W-1.
- k = 0 is passthrough in both modes.
- `out_sof` is set on the output generated from output coordinate (0,0). `out_eol` is set when output x = (IMG_W>>k)-1.

## Timing
- The output register is single-entry. `in_ready = !out_valid || out_ready` (combinational).
- Latency: the output is valid on the cycle after the triggering input transfer.
- Throughput: with `out_ready` held high, one pixel per cycle in and one pixel per cycle out when k = 0.
- `out_pixel`, `out_sof` and `out_eol` are held stable while `out_valid && !out_ready`.
- Transfers that do not generate an output are still accepted only when `in_ready` is high. This keeps the handshake rule uniform.
- `frame_done` pulses the cycle after the output with output coordinate (last, last) is accepted.
- Reset values: `out_valid`=0, `out_pixel`=0, `out_sof`=0, `out_eol`=0, `frame_done`=0, `in_ready`=1; counters=(0,0); latched config = (k=MAX_LOG2, drop).
- The accumulator RAM is not reset; the first-of-block write makes its prior contents irrelevant.
- Reset mid-frame: the pending output is lost, and the next accepted pixel is (0,0).

## Structure
- Package `decim_pkg` holds:
  - the mode enum `DECIM_DROP`/`DECIM_AVG`;
  - the accumulator width function;
  - the clamp function for `cfg_log2`.
- Sub-module `decim_linha_acc`: the row accumulator. It is a synchronous-write, combinational-read RAM indexed by `x>>k`, with write-or-accumulate control.
- Top level: counters, config latch, output register and handshake.

## Test plan
- 160×120 ramp frame with `pixel = (x+y)&0xFF`, k=2, drop → exactly 1200 outputs, with output (i,j) = `(4i+4j)&0xFF`. `out_sof` on the first output; `out_eol` every 40 outputs; one `frame_done`.
- k=2, average: each 4×4 block holds the values 0..15 → every output is 8 (120/16 = 7.5, rounded up). A constant-200 frame → all outputs 200.
- k=0, both modes → output stream identical to the input stream; 19200 outputs; latency 1 cycle.
- `out_ready` low for 5 cycles while an output is pending → `in_ready` low for those cycles, with no input or output lost or duplicated. The output count and checksum match the no-stall run.
- `cfg_log2` changed from 2 to 1 mid-frame → the current frame still yields 1200 outputs; the next frame yields 4800. `cfg_log2`=3 → treated as 2.
- Cases that restart the frame:
  - `in_sof` asserted at input pixel (37,5) → counting restarts, and a full correct frame follows.
  - `rst_n` low for 2 cycles mid-frame → `out_valid`=0 immediately, and the next frame is correct.
